// File: rtl/branch_ctrl.sv
// Branch resolution controller: latches a branch, drives an external comparator,
// resolves direction/target after a fixed 2-cycle latency and trains a 16-entry BHT.
module branch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  br_funct3,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_imm,
    input  logic        br_pred,
    output logic [1:0]  cmp_mode,
    input  logic        cmp_eq,
    input  logic        cmp_lt,
    output logic        res_valid,
    output logic        res_taken,
    output logic [31:0] res_target,
    output logic        res_flush,
    output logic        res_illegal,
    input  logic [31:0] pq_pc,
    output logic        pq_taken
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMP     = 2'd1,
        RESOLVE = 2'd2
    } state_e;

    localparam logic [1:0] MODE_OFF      = 2'b00;
    localparam logic [1:0] MODE_UNSIGNED = 2'b01;
    localparam logic [1:0] MODE_SIGNED   = 2'b11;

    state_e      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] imm_q, imm_d;
    logic        pred_q, pred_d;
    logic        eq_q, eq_d;
    logic        lt_q, lt_d;

    logic        accept;
    logic        legal;
    logic        taken;
    logic        upd_en;
    logic [3:0]  upd_idx;
    logic [31:0] bht_vec;
    logic        unused_pq_bits;

    assign accept = (state_q == IDLE) && br_valid;

    // ------------------------------------------------------------------
    // Control FSM and request/compare latches
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        pc_d     = pc_q;
        imm_d    = imm_q;
        pred_d   = pred_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    funct3_d = br_funct3;
                    pc_d     = br_pc;
                    imm_d    = br_imm;
                    pred_d   = br_pred;
                    state_d  = CMP;
                end
            end
            CMP: begin
                eq_d    = cmp_eq;
                lt_d    = cmp_lt;
                state_d = RESOLVE;
            end
            RESOLVE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            funct3_q <= 3'd0;
            pc_q     <= 32'd0;
            imm_q    <= 32'd0;
            pred_q   <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            pc_q     <= pc_d;
            imm_q    <= imm_d;
            pred_q   <= pred_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
        end
    end

    // ------------------------------------------------------------------
    // Direction decode from the latched funct3 and registered compare flags
    // ------------------------------------------------------------------
    always_comb begin
        legal = 1'b1;
        taken = 1'b0;
        case (funct3_q)
            3'b000:  taken = eq_q;
            3'b001:  taken = !eq_q;
            3'b100:  taken = lt_q;
            3'b101:  taken = !lt_q;
            3'b110:  taken = lt_q;
            3'b111:  taken = !lt_q;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        cmp_mode = MODE_OFF;
        if (state_q == CMP) begin
            case (funct3_q)
                3'b000, 3'b001, 3'b100, 3'b101: cmp_mode = MODE_SIGNED;
                3'b110, 3'b111:                 cmp_mode = MODE_UNSIGNED;
                default:                        cmp_mode = MODE_OFF;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Resolution outputs; all zero outside the RESOLVE pulse
    // ------------------------------------------------------------------
    always_comb begin
        br_ready    = (state_q == IDLE);
        res_valid   = 1'b0;
        res_taken   = 1'b0;
        res_target  = 32'd0;
        res_flush   = 1'b0;
        res_illegal = 1'b0;
        if (state_q == RESOLVE) begin
            res_valid   = 1'b1;
            res_taken   = taken;
            res_target  = taken ? (pc_q + imm_q) : (pc_q + 32'd4);
            res_flush   = (taken != pred_q);
            res_illegal = !legal;
        end
    end

    // ------------------------------------------------------------------
    // Branch history table: 16 x 2-bit saturating counters
    // ------------------------------------------------------------------
    assign upd_en  = (state_q == RESOLVE) && legal;
    assign upd_idx = pc_q[5:2];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bht
            logic [1:0] ctr_q, ctr_d;

            always_comb begin
                ctr_d = ctr_q;
                if (upd_en && (upd_idx == 4'(gi))) begin
                    if (taken) begin
                        if (ctr_q != 2'b11) ctr_d = ctr_q + 2'd1;
                    end else begin
                        if (ctr_q != 2'b00) ctr_d = ctr_q - 2'd1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) ctr_q <= 2'b01;
                else     ctr_q <= ctr_d;
            end

            assign bht_vec[gi*2 +: 2] = ctr_q;
        end
    endgenerate

    // Reads the registered counters, so a same-cycle update is not yet visible
    assign pq_taken = bht_vec[{pq_pc[5:2], 1'b1}];

    assign unused_pq_bits = ^{pq_pc[31:6], pq_pc[1:0]};

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed-vector bench for branch_ctrl: hand-computed resolution results and
// BHT state observed through the prediction query port.
module tb_branch_ctrl;

    logic        clk;
    logic        rst;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_funct3;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic        br_pred;
    logic [1:0]  cmp_mode;
    logic        cmp_eq;
    logic        cmp_lt;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_flush;
    logic        res_illegal;
    logic [31:0] pq_pc;
    logic        pq_taken;

    int n_checks = 0;
    int n_fail   = 0;

    branch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .br_valid    (br_valid),
        .br_ready    (br_ready),
        .br_funct3   (br_funct3),
        .br_pc       (br_pc),
        .br_imm      (br_imm),
        .br_pred     (br_pred),
        .cmp_mode    (cmp_mode),
        .cmp_eq      (cmp_eq),
        .cmp_lt      (cmp_lt),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .res_target  (res_target),
        .res_flush   (res_flush),
        .res_illegal (res_illegal),
        .pq_pc       (pq_pc),
        .pq_taken    (pq_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One full transaction: accept (T), compare (T+1), resolve (T+2), back to IDLE.
    task automatic do_branch(input string tag, input logic [2:0] f3, input logic [31:0] pc,
                             input logic [31:0] imm, input logic pred, input logic eq,
                             input logic lt, input logic [1:0] e_mode, input logic e_taken,
                             input logic [31:0] e_tgt, input logic e_flush, input logic e_ill,
                             input logic e_pq_old, input logic e_pq_new);
        br_valid  = 1'b1;
        br_funct3 = f3;
        br_pc     = pc;
        br_imm    = imm;
        br_pred   = pred;
        pq_pc     = pc;
        check({tag, ":ready_idle"}, 32'(br_ready), 32'd1);
        check({tag, ":pq_before"}, 32'(pq_taken), 32'(e_pq_old));
        tick();
        // Scramble request inputs to prove the fields were latched
        br_valid  = 1'b0;
        br_funct3 = ~f3;
        br_pc     = 32'hDEAD_BEEF;
        br_imm    = 32'h1234_5678;
        br_pred   = ~pred;
        cmp_eq    = eq;
        cmp_lt    = lt;
        check({tag, ":cmp_mode"}, 32'(cmp_mode), 32'(e_mode));
        check({tag, ":ready_cmp"}, 32'(br_ready), 32'd0);
        check({tag, ":valid_cmp"}, 32'(res_valid), 32'd0);
        tick();
        cmp_eq = ~eq;
        cmp_lt = ~lt;
        check({tag, ":valid"}, 32'(res_valid), 32'd1);
        check({tag, ":ready_res"}, 32'(br_ready), 32'd0);
        check({tag, ":mode_res"}, 32'(cmp_mode), 32'd0);
        check({tag, ":taken"}, 32'(res_taken), 32'(e_taken));
        check({tag, ":target"}, res_target, e_tgt);
        check({tag, ":flush"}, 32'(res_flush), 32'(e_flush));
        check({tag, ":illegal"}, 32'(res_illegal), 32'(e_ill));
        check({tag, ":pq_during"}, 32'(pq_taken), 32'(e_pq_old));
        tick();
        check({tag, ":valid_after"}, 32'(res_valid), 32'd0);
        check({tag, ":res_zero"}, {res_taken, res_flush, res_illegal}, 32'd0);
        check({tag, ":target_zero"}, res_target, 32'd0);
        check({tag, ":ready_after"}, 32'(br_ready), 32'd1);
        check({tag, ":pq_after"}, 32'(pq_taken), 32'(e_pq_new));
        $display("txn %s f3=%0d pc=0x%08h done", tag, f3, pc);
    endtask

    initial begin
        rst       = 1'b1;
        br_valid  = 1'b0;
        br_funct3 = 3'd0;
        br_pc     = 32'd0;
        br_imm    = 32'd0;
        br_pred   = 1'b0;
        cmp_eq    = 1'b0;
        cmp_lt    = 1'b0;
        pq_pc     = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        check("rst:ready", 32'(br_ready), 32'd1);
        check("rst:mode", 32'(cmp_mode), 32'd0);
        check("rst:valid", 32'(res_valid), 32'd0);
        check("rst:target", res_target, 32'd0);
        check("rst:pq", 32'(pq_taken), 32'd0);

        // BEQ taken, mispredicted not-taken; table[0] 01->10
        do_branch("beq", 3'b000, 32'h100, 32'h20, 1'b0, 1'b1, 1'b0,
                  2'b11, 1'b1, 32'h120, 1'b1, 1'b0, 1'b0, 1'b1);

        // BLTU not taken with wrapping target; table[15] 01->00, then BGEU shows 00->01
        do_reset();
        do_branch("bltu", 3'b110, 32'hFFFF_FFFC, 32'd8, 1'b1, 1'b0, 1'b0,
                  2'b01, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_branch("bgeu", 3'b111, 32'hFFFF_FFFC, 32'd8, 1'b0, 1'b0, 1'b0,
                  2'b01, 1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);

        // Illegal funct3: no table change, flush follows pred
        do_reset();
        do_branch("ill010", 3'b010, 32'h200, 32'h10, 1'b0, 1'b1, 1'b1,
                  2'b00, 1'b0, 32'h204, 1'b0, 1'b1, 1'b0, 1'b0);
        do_branch("ill011", 3'b011, 32'h8, 32'h10, 1'b1, 1'b1, 1'b1,
                  2'b00, 1'b0, 32'hC, 1'b1, 1'b1, 1'b0, 1'b0);
        do_branch("bne_post_ill", 3'b001, 32'h8, 32'h10, 1'b0, 1'b0, 1'b0,
                  2'b11, 1'b1, 32'h18, 1'b1, 1'b0, 1'b0, 1'b1);

        // Saturation: three taken BNEs then one not-taken (11->10 stays predicted taken)
        do_reset();
        do_branch("bne1", 3'b001, 32'h40, 32'h10, 1'b1, 1'b0, 1'b0,
                  2'b11, 1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 1'b1);
        do_branch("bne2", 3'b001, 32'h40, 32'h10, 1'b1, 1'b0, 1'b0,
                  2'b11, 1'b1, 32'h50, 1'b0, 1'b0, 1'b1, 1'b1);
        do_branch("bne3", 3'b001, 32'h40, 32'h10, 1'b1, 1'b0, 1'b0,
                  2'b11, 1'b1, 32'h50, 1'b0, 1'b0, 1'b1, 1'b1);
        do_branch("bne_nt", 3'b001, 32'h40, 32'h10, 1'b1, 1'b1, 1'b0,
                  2'b11, 1'b0, 32'h44, 1'b1, 1'b0, 1'b1, 1'b1);

        // Signed compares with negative offset
        do_reset();
        do_branch("blt", 3'b100, 32'h1000, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1,
                  2'b11, 1'b1, 32'hFF0, 1'b1, 1'b0, 1'b0, 1'b1);
        do_branch("bge", 3'b101, 32'h1000, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1,
                  2'b11, 1'b0, 32'h1004, 1'b0, 1'b0, 1'b1, 1'b0);

        // br_valid held high: acceptance every 3 cycles
        do_reset();
        br_valid  = 1'b1;
        br_funct3 = 3'b000;
        br_pc     = 32'h300;
        br_imm    = 32'd4;
        br_pred   = 1'b1;
        cmp_eq    = 1'b1;
        begin
            int accepts = 0;
            for (int i = 0; i < 9; i++) begin
                check($sformatf("stream:ready%0d", i), 32'(br_ready), 32'((i % 3) == 0));
                check($sformatf("stream:valid%0d", i), 32'(res_valid), 32'((i % 3) == 2));
                if (br_ready) accepts++;
                tick();
            end
            check("stream:accepts", 32'(accepts), 32'd3);
            $display("txn stream accepts=%0d", accepts);
        end
        br_valid = 1'b0;
        tick();
        tick();
        tick();

        // Reset during CMP aborts; table[0] was trained to 10 and must return to 01
        do_reset();
        do_branch("train0", 3'b000, 32'h0, 32'h20, 1'b0, 1'b1, 1'b0,
                  2'b11, 1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1);
        br_valid  = 1'b1;
        br_funct3 = 3'b000;
        br_pc     = 32'h0;
        pq_pc     = 32'h0;
        tick();
        br_valid = 1'b0;
        check("rstcmp:in_cmp", 32'(cmp_mode), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstcmp:ready", 32'(br_ready), 32'd1);
        check("rstcmp:valid", 32'(res_valid), 32'd0);
        check("rstcmp:mode", 32'(cmp_mode), 32'd0);
        tick();
        check("rstcmp:valid_next", 32'(res_valid), 32'd0);
        for (int e = 0; e < 16; e++) begin
            pq_pc = 32'(e) << 2;
            #1;
            check($sformatf("rstcmp:pq%0d", e), 32'(pq_taken), 32'd0);
        end
        $display("txn reset_in_cmp done");

        // Reset during RESOLVE: no pulse continues and no table update
        br_valid  = 1'b1;
        br_funct3 = 3'b000;
        br_pc     = 32'h0;
        pq_pc     = 32'h0;
        cmp_eq    = 1'b1;
        tick();
        br_valid = 1'b0;
        tick();
        check("rstres:in_res", 32'(res_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstres:valid", 32'(res_valid), 32'd0);
        check("rstres:pq", 32'(pq_taken), 32'd0);
        $display("txn reset_in_resolve done");

        // Reset beats a simultaneous request
        br_valid  = 1'b1;
        br_funct3 = 3'b000;
        rst       = 1'b1;
        tick();
        rst      = 1'b0;
        br_valid = 1'b0;
        check("rstprio:ready", 32'(br_ready), 32'd1);
        check("rstprio:mode", 32'(cmp_mode), 32'd0);
        tick();
        check("rstprio:valid", 32'(res_valid), 32'd0);
        $display("txn reset_priority done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The module SHALL expose these ports, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- br_valid  in  1  branch request valid.
- br_ready  out  1  controller can accept a request.
- br_funct3  in  3  branch funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
- br_pc  in  32  branch instruction PC.
- br_imm  in  32  sign-extended branch offset.
- br_pred  in  1  prediction the front end used for this branch.
- cmp_mode  out  2  comparator mode: 00 off, 01 unsigned, 11 signed.
- cmp_eq  in  1  comparator equal result.
- cmp_lt  in  1  comparator less-than result.
- res_valid  out  1  one-cycle resolution pulse.
- res_taken  out  1  resolved direction.
- res_target  out  32  next PC.
- res_flush  out  1  mispredict; flush younger instructions.
- res_illegal  out  1  funct3 not a branch encoding.
- pq_pc  in  32  prediction query PC.
- pq_taken  out  1  predicted direction for pq_pc.

Function
REQ-002 The controller SHALL implement three states: IDLE, CMP and RESOLVE.
REQ-003 br_ready SHALL be 1 in IDLE only, and 0 in CMP and RESOLVE.
REQ-004 A request SHALL be accepted on a cycle with br_valid=1 and br_ready=1 (cycle T).
- On acceptance it SHALL latch funct3, pc, imm and pred, and go IDLE->CMP.
REQ-005 In CMP (cycle T+1), cmp_mode SHALL drive the comparator:
- 11 for funct3 000/001/100/101.
- 01 for 110/111.
- 00 for 010/011.
REQ-006 cmp_mode SHALL be 00 in IDLE and RESOLVE.
REQ-007 cmp_eq and cmp_lt SHALL be registered at the end of CMP, and the state SHALL go CMP->RESOLVE unconditionally.
REQ-008 In RESOLVE (cycle T+2), res_valid SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE; fixed latency is 2 cycles from acceptance.
REQ-009 Taken SHALL be computed as:
- BEQ: eq.
- BNE: !eq.
- BLT and BLTU: lt.
- BGE and BGEU: !lt.
- 010 and 011: 0, with res_illegal=1.
REQ-010 res_target SHALL be pc+imm if taken, else pc+4, as modulo-2^32 addition (wrap-around, no overflow flag).
REQ-011 res_flush SHALL be (taken != latched pred) during RESOLVE, and 0 whenever res_valid=0.
- An illegal funct3 SHALL give res_flush = latched pred.
REQ-012 The block SHALL hold a 16-entry table of 2-bit saturating counters, indexed by pc[5:2].
REQ-013 pq_taken SHALL be combinational: table[pq_pc[5:2]][1].
REQ-014 In RESOLVE, for legal funct3, the indexed counter SHALL update at the clock edge ending RESOLVE:
- Taken: increment, saturating at 11.
- Not taken: decrement, saturating at 00.
REQ-015 An illegal funct3 SHALL NOT update the table.
REQ-016 A query to the entry being updated in the same cycle SHALL return the pre-update value.
REQ-017 res_taken, res_target, res_flush and res_illegal SHALL be 0 whenever res_valid=0.
REQ-018 Requests presented while br_ready=0 SHALL be ignored; the requester SHALL hold br_valid until accepted.

Reset
REQ-019 When rst=1 at a clock edge:
- state SHALL become IDLE;
- all table entries SHALL become 01 (weakly not-taken);
- latched fields SHALL become 0.
REQ-020 During and after reset, br_ready SHALL be 1 (IDLE) and cmp_mode/res_* SHALL be 0.
REQ-021 Reset in CMP or RESOLVE SHALL abort the transaction: no res_valid pulse and no table update.
REQ-022 rst SHALL take priority over a simultaneous br_valid; the request SHALL NOT be accepted.

Verification
REQ-023 BEQ, pc=0x100, imm=0x20, pred=0, eq=1 -> cmp_mode=11 at T+1; at T+2: res_valid=1, taken=1, target=0x120, flush=1; table[0] goes 01->10.
REQ-024 BLTU, pc=0xFFFFFFFC, imm=8, pred=1, lt=0 -> cmp_mode=01; taken=0, target=0x00000000 (wrap), flush=1; table[15] goes 01->00.
REQ-025 funct3=010, pred=0 -> cmp_mode=00; res_illegal=1, taken=0, target=pc+4, flush=0; table unchanged.
REQ-026 Three taken BNEs at pc=0x40 -> table[0] goes 01->10->11->11 (saturates); pq_pc=0x40 reads 1 after the first update, and the old value during each RESOLVE cycle.
REQ-027 br_valid held high continuously -> acceptances occur every 3 cycles, br_ready low in CMP and RESOLVE, no request lost.
REQ-028 rst=1 during CMP -> next cycle IDLE, br_ready=1, no res_valid, table all 01.
